// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared ALU/RV32M op encodings and muldiv FSM states
package muldiv_unit_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: one-bit-per-cycle restoring divider on unsigned magnitudes
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_nxt,
  output logic [WIDTH-1:0] rem_nxt
);
  logic [WIDTH-1:0] q, r, d;
  logic [WIDTH:0] r_sh, diff;
  logic ge;
  always_comb begin
    r_sh = {r, q[WIDTH-1]};
    diff = r_sh - {1'b0, d};
    ge = !diff[WIDTH];
    quo_nxt = {q[WIDTH-2:0], ge};
    rem_nxt = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      r <= '0;
      d <= '0;
    end else if (load) begin
      q <= dividend;
      r <= '0;
      d <= divisor;
    end else if (step) begin
      q <= quo_nxt;
      r <= rem_nxt;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready handshake.
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier instead of shift-add.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  input  logic             flush
);
  state_e state, state_nxt;
  logic [2:0] op;
  logic [4:0] cnt;
  logic qneg, rneg, accept, div_op, a_sgn, b_sgn, special;
  logic [WIDTH:0] a_ext, b_ext;
  logic [WIDTH-1:0] da, db, special_res, quo_nxt, rem_nxt, div_res;
`ifdef MULDIV_FAST_MUL_EN
  localparam state_e MUL_DST = DONE;
  logic signed [2*WIDTH+1:0] prod;
`else
  localparam state_e MUL_DST = MUL;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0] mplier;
`endif
  assign req_ready = state == IDLE;
  assign resp_valid = state == DONE;
  always_comb begin
    accept = req_valid && req_ready && !flush;
    div_op = req_op[2];
    a_sgn = div_op ? !req_op[0] : (req_op == MD_MULH || req_op == MD_MULHSU);
    b_sgn = div_op ? !req_op[0] : req_op == MD_MULH;
    a_ext = {a_sgn & req_a[WIDTH-1], req_a};
    b_ext = {b_sgn & req_b[WIDTH-1], req_b};
    da = a_ext[WIDTH] ? -req_a : req_a;
    db = b_ext[WIDTH] ? -req_b : req_b;
    special = div_op && (req_b == '0 || (!req_op[0] && req_a == {1'b1, {(WIDTH-1){1'b0}}} && req_b == '1));
    special_res = req_b == '0 ? (req_op[1] ? req_a : '1) : (req_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});
    div_res = op[1] ? (rneg ? -rem_nxt : rem_nxt) : (qneg ? -quo_nxt : quo_nxt);
`ifdef MULDIV_FAST_MUL_EN
    prod = $signed(a_ext) * $signed(b_ext);
`else
    acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = accept ? (special ? DONE : (div_op ? DIV : MUL_DST)) : IDLE;
      MUL, DIV: state_nxt = cnt == '1 ? DONE : state;
      DONE: state_nxt = resp_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .step(state == DIV),
    .dividend(da),
    .divisor(db),
    .quo_nxt(quo_nxt),
    .rem_nxt(rem_nxt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      op <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      resp_result <= '0;
`ifndef MULDIV_FAST_MUL_EN
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
`endif
    end else begin
      cnt <= (state == MUL || state == DIV) ? cnt + 5'd1 : '0;
      if (accept) begin
        op <= req_op;
        qneg <= a_ext[WIDTH] ^ b_ext[WIDTH];
        rneg <= a_ext[WIDTH];
        if (special) resp_result <= special_res;
`ifdef MULDIV_FAST_MUL_EN
        if (!div_op) resp_result <= req_op == MD_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`else
        // multiplier sign bit has weight -2^WIDTH, so preload its contribution
        acc <= b_ext[WIDTH] ? -{req_a, {WIDTH{1'b0}}} : '0;
        mcand <= {{(WIDTH-1){a_ext[WIDTH]}}, a_ext};
        mplier <= req_b;
`endif
      end
`ifndef MULDIV_FAST_MUL_EN
      if (state == MUL) begin
        acc <= acc_nxt;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        if (cnt == '1) resp_result <= op == MD_MUL ? acc_nxt[WIDTH-1:0] : acc_nxt[2*WIDTH-1:WIDTH];
      end
`endif
      if (state == DIV && cnt == '1) resp_result <= div_res;
    end
  end
endmodule
